// File: rtl/pio_irq_master.sv
// pio_irq_master
// Avalon-MM master that services an edge-capturing button PIO without a CPU.
// After reset it programs the PIO irq mask once. On each irq it reads the
// edge-capture register, clears it, and hands the captured bits downstream
// as a valid/ready event.
// Edges the PIO detects during the READ and CLEAR cycles are lost, because
// the clear write wipes every capture bit. Software is told about this.

module pio_irq_master #(
   parameter int               WIDTH     = 4,
   parameter logic [WIDTH-1:0] MASK_INIT = 4'hF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   output logic [1:0]       m_address,
   output logic             m_chipselect,
   output logic             m_write_n,
   output logic [31:0]      m_writedata,
   input  logic [31:0]      m_readdata,
   input  logic             irq_in,
   output logic             init_done,
   output logic             event_valid,
   output logic [WIDTH-1:0] event_data,
   input  logic             event_ready
);

   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // ST_START holds the bus idle for the first cycle after reset. Bus outputs
   // are registered from the next state, so the mask write becomes visible in
   // the cycle spent in ST_INIT.
   typedef enum logic [2:0] {
      ST_START = 3'd0,
      ST_INIT  = 3'd1,
      ST_IDLE  = 3'd2,
      ST_READ  = 3'd3,
      ST_CLEAR = 3'd4,
      ST_HOLD  = 3'd5
   } state_t;

   // Zero-extend the WIDTH-bit mask onto the 32-bit write data bus.
   function automatic logic [31:0] mask_word(input logic [WIDTH-1:0] mask);
      logic [31:0] word;
      word = 32'h0000_0000;
      word[WIDTH-1:0] = mask;
      return word;
   endfunction

   state_t           state_r;
   state_t           next_state_s;
   logic             cs_s;
   logic             write_n_s;
   logic [1:0]       addr_s;
   logic [31:0]      wdata_s;
   logic             load_event_s;
   logic [WIDTH-1:0] capture_s;

   logic             cs_r;
   logic             write_n_r;
   logic [1:0]       addr_r;
   logic [31:0]      wdata_r;
   logic             event_valid_r;
   logic [WIDTH-1:0] event_data_r;
   logic             init_done_r;

   // Only the low WIDTH bits of the PIO read data are meaningful.
   logic             unused_rdata_s;
   assign unused_rdata_s = ^m_readdata;

   // In CLEAR the read data from the preceding READ is on m_readdata.
   assign capture_s = m_readdata[WIDTH-1:0];

   // Next-state selection and decode of the bus transaction for that state.
   always_comb begin
      next_state_s = state_r;
      cs_s         = 1'b0;
      write_n_s    = 1'b1;
      addr_s       = ADDR_DATA;
      wdata_s      = 32'h0000_0000;
      load_event_s = 1'b0;

      case (state_r)
         ST_START: begin
            next_state_s = ST_INIT;
         end
         ST_INIT: begin
            next_state_s = ST_IDLE;
         end
         ST_IDLE: begin
            if (irq_in && enable) begin
               next_state_s = ST_READ;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_READ: begin
            next_state_s = ST_CLEAR;
         end
         ST_CLEAR: begin
            if (capture_s != {WIDTH{1'b0}}) begin
               next_state_s = ST_HOLD;
               load_event_s = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_HOLD: begin
            if (event_ready) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_HOLD;
            end
         end
         default: begin
            next_state_s = ST_START;
         end
      endcase

      case (next_state_s)
         ST_INIT: begin
            cs_s      = 1'b1;
            write_n_s = 1'b0;
            addr_s    = ADDR_MASK;
            wdata_s   = mask_word(MASK_INIT);
         end
         ST_READ: begin
            cs_s      = 1'b1;
            write_n_s = 1'b1;
            addr_s    = ADDR_EDGE;
         end
         ST_CLEAR: begin
            cs_s      = 1'b1;
            write_n_s = 1'b0;
            addr_s    = ADDR_EDGE;
            wdata_s   = 32'h0000_0000;
         end
         default: begin
            cs_s      = 1'b0;
            write_n_s = 1'b1;
            addr_s    = ADDR_DATA;
            wdata_s   = 32'h0000_0000;
         end
      endcase
   end

   // State register and registered bus/event outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r       <= ST_START;
         cs_r          <= 1'b0;
         write_n_r     <= 1'b1;
         addr_r        <= ADDR_DATA;
         wdata_r       <= 32'h0000_0000;
         event_valid_r <= 1'b0;
         event_data_r  <= {WIDTH{1'b0}};
         init_done_r   <= 1'b0;
      end else begin
         state_r       <= next_state_s;
         cs_r          <= cs_s;
         write_n_r     <= write_n_s;
         addr_r        <= addr_s;
         wdata_r       <= wdata_s;
         event_valid_r <= (next_state_s == ST_HOLD);
         if (load_event_s) begin
            event_data_r <= capture_s;
         end else begin
            event_data_r <= event_data_r;
         end
         if (state_r == ST_INIT) begin
            init_done_r <= 1'b1;
         end else begin
            init_done_r <= init_done_r;
         end
      end
   end

   assign m_chipselect = cs_r;
   assign m_write_n    = write_n_r;
   assign m_address    = addr_r;
   assign m_writedata  = wdata_r;
   assign event_valid  = event_valid_r;
   assign event_data   = event_data_r;
   assign init_done    = init_done_r;

endmodule

// File: tb/tb_pio_irq_master.sv
// Directed bench for pio_irq_master with a small model of the button PIO
// (edge capture, irq mask, registered read data, clear-on-write).

module tb_pio_irq_master;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [1:0]  m_address;
   logic        m_chipselect;
   logic        m_write_n;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata;
   logic        irq_in;
   logic        init_done;
   logic        event_valid;
   logic [3:0]  event_data;
   logic        event_ready;

   logic [3:0]  pio_cap;
   logic [3:0]  pio_mask;
   logic [3:0]  press_req;
   logic        force_irq;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clk = ~clk;

   pio_irq_master #(.WIDTH(4), .MASK_INIT(4'hF)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .enable       (enable),
      .m_address    (m_address),
      .m_chipselect (m_chipselect),
      .m_write_n    (m_write_n),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata),
      .irq_in       (irq_in),
      .init_done    (init_done),
      .event_valid  (event_valid),
      .event_data   (event_data),
      .event_ready  (event_ready)
   );

   // Button PIO model: captures presses, clears on write to offset 3.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pio_cap    <= 4'h0;
         pio_mask   <= 4'h0;
         m_readdata <= 32'h0;
      end else begin
         if (m_chipselect && !m_write_n && m_address == 2'd3) pio_cap <= 4'h0;
         else                                                   pio_cap <= pio_cap | press_req;
         if (m_chipselect && !m_write_n && m_address == 2'd2) pio_mask <= m_writedata[3:0];
         case (m_address)
            2'd2:    m_readdata <= {28'h0, pio_mask};
            2'd3:    m_readdata <= {28'h0, pio_cap};
            default: m_readdata <= 32'h0;
         endcase
      end
   end

   assign irq_in = (|(pio_cap & pio_mask)) | force_irq;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] bits);
      press_req = bits;
      tick();
      press_req = 4'h0;
   endtask

   // {chipselect, write_n, address}
   function automatic logic [31:0] bus();
      return {28'h0, m_chipselect, m_write_n, m_address};
   endfunction

   initial begin
      reset_n     = 1'b0;
      enable      = 1'b1;
      event_ready = 1'b1;
      press_req   = 4'h0;
      force_irq   = 1'b0;
      repeat (3) tick();

      // Reset state
      check_val("rst_bus",   bus(), 32'h4);
      check_val("rst_wdata", m_writedata, 32'h0);
      check_val("rst_valid", {31'h0, event_valid}, 32'h0);
      check_val("rst_data",  {28'h0, event_data}, 32'h0);
      check_val("rst_init",  {31'h0, init_done}, 32'h0);

      // Mask write in the first cycle after release
      reset_n = 1'b1;
      tick();
      check_val("init_bus",   bus(), 32'hA);
      check_val("init_wdata", m_writedata, 32'hF);
      check_val("init_done0", {31'h0, init_done}, 32'h0);
      tick();
      check_val("init_done1", {31'h0, init_done}, 32'h1);
      check_val("init_idle",  bus(), 32'h4);

      // Single press on bit 2
      press(4'h4);
      check_val("p2_idle",  bus(), 32'h4);
      tick();
      check_val("p2_read",  bus(), 32'hF);
      tick();
      check_val("p2_clear", bus(), 32'hB);
      check_val("p2_cwd",   m_writedata, 32'h0);
      check_val("p2_nv",    {31'h0, event_valid}, 32'h0);
      tick();
      check_val("p2_valid", {31'h0, event_valid}, 32'h1);
      check_val("p2_data",  {28'h0, event_data}, 32'h4);
      check_val("p2_hbus",  bus(), 32'h4);
      tick();
      check_val("p2_drop",  {31'h0, event_valid}, 32'h0);
      check_val("p2_irq",   {31'h0, irq_in}, 32'h0);

      // Backpressure: event 0x1 held 20 cycles while bit 3 is pressed
      event_ready = 1'b0;
      press(4'h1);
      tick();
      tick();
      tick();
      check_val("bp_valid", {31'h0, event_valid}, 32'h1);
      check_val("bp_data",  {28'h0, event_data}, 32'h1);
      for (int i = 0; i < 20; i++) begin
         press_req = (i == 0) ? 4'h8 : 4'h0;
         tick();
         check_val("bp_hold", {event_valid, m_chipselect, 26'h0, event_data}, 32'h8000_0001);
      end
      press_req = 4'h0;
      event_ready = 1'b1;
      tick();
      check_val("bp_acc",   {31'h0, event_valid}, 32'h0);
      tick();
      check_val("bp_read2", bus(), 32'hF);
      tick();
      check_val("bp_clr2",  bus(), 32'hB);
      tick();
      check_val("bp_v2",    {31'h0, event_valid}, 32'h1);
      check_val("bp_d2",    {28'h0, event_data}, 32'h8);
      tick();
      check_val("bp_drop2", {31'h0, event_valid}, 32'h0);

      // Spurious irq: capture reads back zero
      force_irq = 1'b1;
      tick();
      check_val("sp_read",  bus(), 32'hF);
      force_irq = 1'b0;
      tick();
      check_val("sp_clear", bus(), 32'hB);
      tick();
      check_val("sp_nv",    {31'h0, event_valid}, 32'h0);
      check_val("sp_idle",  bus(), 32'h4);
      tick();
      check_val("sp_idle2", bus(), 32'h4);
      check_val("sp_nv2",   {31'h0, event_valid}, 32'h0);

      // enable gating
      enable = 1'b0;
      press(4'h2);
      tick();
      check_val("en_noread0", bus(), 32'h4);
      tick();
      check_val("en_noread1", bus(), 32'h4);
      enable = 1'b1;
      tick();
      check_val("en_read",  bus(), 32'hF);
      tick();
      check_val("en_clear", bus(), 32'hB);
      enable = 1'b0;
      tick();
      check_val("en_valid", {31'h0, event_valid}, 32'h1);
      check_val("en_data",  {28'h0, event_data}, 32'h2);
      tick();
      check_val("en_drop",  {31'h0, event_valid}, 32'h0);
      press(4'h1);
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("en_idle", bus(), 32'h4);
      end

      // Reset while holding an event
      event_ready = 1'b0;
      enable = 1'b1;
      tick();
      check_val("rh_read", bus(), 32'hF);
      tick();
      tick();
      check_val("rh_valid", {31'h0, event_valid}, 32'h1);
      check_val("rh_data",  {28'h0, event_data}, 32'h1);
      reset_n = 1'b0;
      #1;
      check_val("rh_rvalid", {31'h0, event_valid}, 32'h0);
      check_val("rh_rcs",    {31'h0, m_chipselect}, 32'h0);
      check_val("rh_rinit",  {31'h0, init_done}, 32'h0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check_val("rh_init",  bus(), 32'hA);
      check_val("rh_wdata", m_writedata, 32'hF);
      tick();
      check_val("rh_done",  {31'h0, init_done}, 32'h1);
      check_val("rh_idle",  bus(), 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
